// File: rtl/ps2_key_ctrl_if.sv
// Bundle of the byte-in, event-out and key-status signals of ps2_key_ctrl.
// slave is the controller side; master is the receiver/consumer side.
interface ps2_key_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_err;
  logic             ev_valid;
  logic [9:0]       ev_data;
  logic             ev_ready;
  logic             key_down;
  logic [7:0]       key_code;
  logic             key_ext;
  logic [CNT_W-1:0] press_count;
  logic             overflow;

  modport slave (
    input  in_valid, in_data, in_err, ev_ready,
    output ev_valid, ev_data, key_down, key_code, key_ext, press_count, overflow
  );

  modport master (
    output in_valid, in_data, in_err, ev_ready,
    input  ev_valid, ev_data, key_down, key_code, key_ext, press_count, overflow
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder: make/break/E0 tracking, typematic suppression,
// held-key status, press counter and a valid/ready event FIFO.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  ps2_key_ctrl_if.slave    bus
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_E0   = 2'd1;
  localparam logic [1:0] S_F0   = 2'd2;
  localparam logic [1:0] S_E0F0 = 2'd3;

  logic [1:0]       state, state_nxt;
  logic             ev_gen, ev_ext, ev_brk;
  logic             key_match, push_req, push, pop, full, empty;
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic [9:0]       mem [FIFO_DEPTH];
  logic             key_down, key_ext, overflow;
  logic [7:0]       key_code;
  logic [CNT_W-1:0] press_count;

  // in_err has priority over a coincident byte and just resyncs the decoder
  always_comb begin
    state_nxt = state;
    ev_gen    = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    if (bus.in_err) begin
      state_nxt = S_IDLE;
    end else if (bus.in_valid) begin
      case (bus.in_data)
        8'hE0:   state_nxt = S_E0;
        8'hF0:   state_nxt = (state == S_E0 || state == S_E0F0) ? S_E0F0 : S_F0;
        default: begin
          state_nxt = S_IDLE;
          ev_gen    = 1'b1;
          ev_ext    = (state == S_E0) || (state == S_E0F0);
          ev_brk    = (state == S_F0) || (state == S_E0F0);
        end
      endcase
    end
  end

  assign key_match = key_down && (ev_ext == key_ext) && (bus.in_data == key_code);
  // a make of the already-held key is a typematic repeat and vanishes entirely
  assign push_req  = ev_gen && (ev_brk || !key_match);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop   = !empty && bus.ev_ready;
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      key_down    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      press_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (ev_gen && !ev_brk && !key_match) begin
        key_down    <= 1'b1;
        key_code    <= bus.in_data;
        key_ext     <= ev_ext;
        press_count <= press_count + 1'b1;
      end
      if (ev_gen && ev_brk && key_match)
        key_down <= 1'b0;
      if (push_req && !push)
        overflow <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[ADDR_W-1:0]] <= {ev_ext, ev_brk, bus.in_data};
  end

  // storage is not cleared on reset, so the head is masked while empty
  assign bus.ev_valid    = !empty;
  assign bus.ev_data     = empty ? 10'd0 : mem[rd_ptr[ADDR_W-1:0]];
  assign bus.key_down    = key_down;
  assign bus.key_code    = key_code;
  assign bus.key_ext     = key_ext;
  assign bus.press_count = press_count;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: table of byte vectors with expected
// key state, plus an event scoreboard and hand-written overflow/reset cases.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_key_ctrl_if #(.CNT_W(CW)) bus ();
  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       err;
    logic       vld;
    logic [7:0] b;
    logic       ev;
    logic [9:0] exp_ev;
    logic       kd;
    logic [7:0] kc;
    logic       ke;
    logic [7:0] cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb[$];
  int         n_checks = 0;
  int         n_errs   = 0;

  function automatic vec_t mk(logic err, logic vld, logic [7:0] b, logic ev,
                              logic [9:0] e, logic kd, logic [7:0] kc,
                              logic ke, logic [7:0] cnt);
    vec_t v;
    v.err = err; v.vld = vld; v.b = b; v.ev = ev; v.exp_ev = e;
    v.kd = kd; v.kc = kc; v.ke = ke; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, score any pop happening at the coming edge
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic rdy);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_err   = e;
    bus.ev_ready = rdy;
    #1;
    if (bus.ev_valid && rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_event: got %0h expected none", bus.ev_data);
      end else begin
        chk("ev_data", {22'd0, bus.ev_data}, {22'd0, sb.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_err   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 4 * DEPTH + 8) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain_timeout: got %0d events missing expected 0", sb.size());
      sb.delete();
    end
    chk("drained_ev_valid", {31'd0, bus.ev_valid}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ev_valid"},  {31'd0, bus.ev_valid}, 32'd0);
    chk({tag, "_ev_data"},   {22'd0, bus.ev_data}, 32'd0);
    chk({tag, "_key_down"},  {31'd0, bus.key_down}, 32'd0);
    chk({tag, "_key_code"},  {24'd0, bus.key_code}, 32'd0);
    chk({tag, "_key_ext"},   {31'd0, bus.key_ext}, 32'd0);
    chk({tag, "_press_cnt"}, {24'd0, bus.press_count}, 32'd0);
    chk({tag, "_overflow"},  {31'd0, bus.overflow}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_err   = 1'b0;
    bus.ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // basic make/break
    vecs.push_back(mk(0,1,8'h1C,1,10'h01C,1,8'h1C,0,1));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h1C,0,1));
    vecs.push_back(mk(0,1,8'h1C,1,10'h11C,0,8'h1C,0,1));
    // extended make/break
    vecs.push_back(mk(0,1,8'hE0,0,10'h000,0,8'h1C,0,1));
    vecs.push_back(mk(0,1,8'h75,1,10'h275,1,8'h75,1,2));
    vecs.push_back(mk(0,1,8'hE0,0,10'h000,1,8'h75,1,2));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h75,1,2));
    vecs.push_back(mk(0,1,8'h75,1,10'h375,0,8'h75,1,2));
    // typematic: five makes, one event
    vecs.push_back(mk(0,1,8'h1C,1,10'h01C,1,8'h1C,0,3));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,8'h1C,0,10'h000,1,8'h1C,0,3));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h1C,0,3));
    vecs.push_back(mk(0,1,8'h1C,1,10'h11C,0,8'h1C,0,3));
    // F0, in_err, 1C -> make
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,0,8'h1C,0,3));
    vecs.push_back(mk(1,0,8'h00,0,10'h000,0,8'h1C,0,3));
    vecs.push_back(mk(0,1,8'h1C,1,10'h01C,1,8'h1C,0,4));
    // F0 E0 74 -> extended make
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h1C,0,4));
    vecs.push_back(mk(0,1,8'hE0,0,10'h000,1,8'h1C,0,4));
    vecs.push_back(mk(0,1,8'h74,1,10'h274,1,8'h74,1,5));
    // break of a non-held key leaves key state alone
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h74,1,5));
    vecs.push_back(mk(0,1,8'h1C,1,10'h11C,1,8'h74,1,5));
    vecs.push_back(mk(0,1,8'hE0,0,10'h000,1,8'h74,1,5));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'h74,1,5));
    vecs.push_back(mk(0,1,8'h74,1,10'h374,0,8'h74,1,5));
    // in_err coinciding with a byte discards the byte
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,0,8'h74,1,5));
    vecs.push_back(mk(1,1,8'h1C,0,10'h000,0,8'h74,1,5));
    vecs.push_back(mk(0,1,8'h1C,1,10'h01C,1,8'h1C,0,6));
    // E1 and AA are plain code bytes; repeated F0 stays in F0
    vecs.push_back(mk(0,1,8'hE1,1,10'h0E1,1,8'hE1,0,7));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'hE1,0,7));
    vecs.push_back(mk(0,1,8'hE1,1,10'h1E1,0,8'hE1,0,7));
    vecs.push_back(mk(0,1,8'hAA,1,10'h0AA,1,8'hAA,0,8));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'hAA,0,8));
    vecs.push_back(mk(0,1,8'hF0,0,10'h000,1,8'hAA,0,8));
    vecs.push_back(mk(0,1,8'hAA,1,10'h1AA,0,8'hAA,0,8));

    foreach (vecs[i]) begin
      if (vecs[i].ev) sb.push_back(vecs[i].exp_ev);
      step(vecs[i].vld, vecs[i].b, vecs[i].err, 1'b1);
      chk($sformatf("v%0d_key_down", i), {31'd0, bus.key_down}, {31'd0, vecs[i].kd});
      chk($sformatf("v%0d_key_code", i), {24'd0, bus.key_code}, {24'd0, vecs[i].kc});
      chk($sformatf("v%0d_key_ext", i),  {31'd0, bus.key_ext},  {31'd0, vecs[i].ke});
      chk($sformatf("v%0d_press_cnt", i), {24'd0, bus.press_count}, {24'd0, vecs[i].cnt});
    end
    drain();
    chk("tbl_overflow", {31'd0, bus.overflow}, 32'd0);

    // overflow: DEPTH+2 distinct makes with the consumer stalled
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) sb.push_back({2'b00, 8'h10 + 8'(i)});
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == DEPTH - 1) chk("ovf_before_drop", {31'd0, bus.overflow}, 32'd0);
      if (i == DEPTH)     chk("ovf_after_drop",  {31'd0, bus.overflow}, 32'd1);
    end
    chk("ovf_press_cnt", {24'd0, bus.press_count}, DEPTH + 2);
    chk("ovf_ev_valid",  {31'd0, bus.ev_valid}, 32'd1);
    chk("ovf_key_code",  {24'd0, bus.key_code}, 32'h10 + DEPTH + 1);
    // full FIFO with simultaneous push and pop must not drop
    sb.push_back(10'h030);
    step(1'b1, 8'h30, 1'b0, 1'b1);
    chk("fullpp_press_cnt", {24'd0, bus.press_count}, DEPTH + 3);
    drain();
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // reset mid-operation: 3 events queued and an E0 pending
    do_reset();
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    chk("pre_rst_ev_valid", {31'd0, bus.ev_valid}, 32'd1);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(10'h075);
    step(1'b1, 8'h75, 1'b0, 1'b1);
    chk("post_rst_key_ext",  {31'd0, bus.key_ext}, 32'd0);
    chk("post_rst_key_code", {24'd0, bus.key_code}, 32'h75);
    chk("post_rst_ev_valid", {31'd0, bus.ev_valid}, 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Scan-code controller that sits between the PS/2 byte receiver and the display/consumer logic. It turns the raw byte stream into key events, tracking make, break and the E0 extended prefix, and suppresses typematic repeats of the held key. It keeps a press counter and the current-key status, and buffers events in a small FIFO drained by a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2
- CNT_W, 8: press_count width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle strobe: in_data holds a received byte
- in_data  in  8  received scan-code byte
- in_err  in  1  one-cycle strobe: receiver dropped a frame (start/stop/parity fail)
- ev_valid  out  1  FIFO non-empty
- ev_data  out  10  head event {ext, brk, code[7:0]}
- ev_ready  in  1  consumer accepts head event
- key_down  out  1  a key is currently held
- key_code  out  8  code of last made key
- key_ext  out  1  last made key was E0-prefixed
- press_count  out  CNT_W  number of non-repeat make events, wraps
- overflow  out  1  sticky: an event was dropped on a full FIFO

## Operation
- Decoder FSM states: IDLE, E0, F0, E0F0. It advances only on in_valid.
- Byte 0xE0 in any state -> E0. This resyncs and discards any pending F0.
- Byte 0xF0: IDLE->F0, E0->E0F0, F0->F0, E0F0->E0F0.
- Any other byte (including 0xE1, 0xAA) is a code byte, which ends the sequence and returns the FSM to IDLE:
  - in IDLE: make, ext=0
  - in E0: make, ext=1
  - in F0: break, ext=0
  - in E0F0: break, ext=1
- in_err (any state) -> IDLE with no event. If in_err and in_valid coincide, in_err wins and the byte is discarded.
- Make event:
  - If key_down=1 and {ext,code}=={key_ext,key_code}, it is a typematic repeat: no push, no count, no state change.
  - Otherwise: key_down<=1, key_code<=code, key_ext<=ext, press_count+=1 (mod 2^CNT_W), push {ext,0,code}.
- Break event:
  - Always pushes {ext,1,code}.
  - If it matches the held key, key_down<=0; key_code and key_ext are retained.
  - A break of a non-held key changes no key state.
- FIFO:
  - Push occurs when an event is generated and the FIFO is not full, or is full with a pop in the same cycle.
  - Otherwise the event is dropped and overflow<=1. Key state and press_count still update on a dropped event.
  - Pop occurs when ev_valid & ev_ready.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.
  - A simultaneous push and pop on an empty FIFO is not allowed to bypass: the new event appears the next cycle.
- Reset values (reset asserted at any clock edge):
  - FSM=IDLE
  - FIFO empty (ev_valid=0)
  - ev_data=0
  - key_down=0, key_code=0, key_ext=0
  - press_count=0
  - overflow=0
- Reset mid-sequence abandons any prefix state.

## Timing
- A byte is sampled at edge N when in_valid=1. At that same edge the FSM, key_*, press_count and the FIFO write all update.
- Latency in_valid -> ev_valid is 1 cycle when the FIFO is empty. ev_data is valid whenever ev_valid=1 and is stable until popped.
- A pop at edge M presents the next entry (or ev_valid=0) after M.
- ev_valid must not depend combinationally on ev_ready.
- Back-to-back in_valid every cycle must be accepted with no loss except on FIFO overflow.
- overflow rises the cycle after the first drop and holds until reset.

## Test plan
- Basic make/break: bytes 0x1C, then F0 1C -> events 0x01C then 0x11C. Check key_down goes 1 then 0, key_code=0x1C, press_count=1.
- Extended key: E0 75, then E0 F0 75 -> events 0x275 then 0x375. Check key_ext=1, and that key_down clears on the break.
- Typematic repeat: 0x1C sent 5 times, then F0 1C -> exactly 2 events, press_count=1.
- Resync: F0, then in_err, then 0x1C -> make 0x01C, not a break. Also F0 E0 74 -> make 0x274.
- Overflow: hold ev_ready=0 and send FIFO_DEPTH+2 distinct makes.
  - Expect FIFO_DEPTH entries buffered and overflow=1.
  - press_count=FIFO_DEPTH+2.
  - Draining returns the first FIFO_DEPTH events in order.
  - Full FIFO with push and pop in the same cycle: no drop.
- Reset mid-operation: assert reset after E0 with 3 events queued.
  - Next cycle: ev_valid=0 and all outputs at 0.
  - A following 0x75 gives make 0x075 with ext=0.
